line_write_merge: RTL and testbench
===================================

Name: line_write_merge

Overview:
- Write-side counterpart of the cache byte-extract path. It accepts single-byte writes (12-bit byte address, 8-bit data), places each byte at its block offset in a 128-bit line buffer, and keeps a 16-bit byte mask of which bytes have been written.
- It sends the merged line to memory with a valid/ready handshake when any of these happens: a full line is collected, a write misses the buffered line, or an explicit flush is requested.
- It sits between the cache write port and main memory (2^8 lines x 16 bytes).

Parameters:
- ADDR_W, 12, byte address width.
- BYTE_W, 8, data byte width.
- LINE_BYTES, 16, bytes per line; OFFSET_W = 4 and TAG_W = ADDR_W - OFFSET_W = 8 are derived, not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_valid  in  1  byte write request.
- wr_ready  out  1  write accepted this cycle when wr_valid & wr_ready.
- wr_addr  in  12  byte address; [11:4] = line address, [3:0] = block offset.
- wr_byte  in  8  write data.
- flush  in  1  single-cycle or level request to push out the buffered line.
- mem_valid  out  1  line available to memory.
- mem_ready  in  1  memory accepts the line when mem_valid & mem_ready.
- mem_line_addr  out  8  line address of the buffered line.
- mem_line  out  128  merged line; byte k is at [8k+7:8k].
- mem_mask  out  16  bit k = 1 if byte k was written.
- busy  out  1  high in MERGING or FLUSH.

Behaviour:
- Reset state: EMPTY. On reset, line = 0, mask = 0, line_addr = 0, mem_valid = 0, busy = 0, wr_ready = 1.
- Reset is asynchronous and applies immediately. Asserting it mid-flush drops the pending line without a handshake.
- wr_ready, mem_valid and busy are decoded from registered state and the current wr_addr only. No combinational path from mem_ready to wr_ready.
- EMPTY:
  - wr_ready = 1.
  - On accept: line_addr <= wr_addr[11:4]; byte at the offset <= wr_byte; other bytes <= 0; mask <= one-hot(offset). Next state MERGING.
  - flush in EMPTY is ignored, so nothing is emitted.
- MERGING:
  - wr_ready = 1 only when wr_addr[11:4] == line_addr (hit).
  - Hit accept: write the byte at its offset and set the mask bit. A repeat write to the same offset overwrites, last write wins.
  - If the mask after the merge is 16'hFFFF, next state FLUSH.
  - A miss (wr_valid with a different line address) gives wr_ready = 0. The write is not consumed and the next state is FLUSH.
  - flush = 1: a same-cycle hit write is merged first, then next state FLUSH. A same-cycle miss write is stalled, then FLUSH.
- FLUSH:
  - mem_valid = 1 and wr_ready = 0.
  - mem_line, mem_mask and mem_line_addr are held stable until the handshake.
  - On mem_valid & mem_ready: mask <= 0, line <= 0, next state EMPTY.
  - A stalled miss write is accepted on the cycle after the handshake (one bubble).
- Latency:
  - Write to buffer: 1 cycle.
  - Earliest mem_valid: the cycle after the completing or triggering event.
  - Minimum FLUSH residency: 1 cycle when mem_ready is held high.
- Bytes never written are 0 in mem_line with their mask bit at 0. Memory must honour the mask.

Decomposition:
- Package cache_pkg:
  - ADDR_W, BYTE_W, LINE_BYTES, OFFSET_W, TAG_W.
  - State encoding: EMPTY = 2'd0, MERGING = 2'd1, FLUSH = 2'd2.
  - FULL_MASK = 16'hFFFF.
- Sub-module offset_2_lane: 4-bit offset to 16-bit one-hot lane enable. It drives both the byte-lane write enables and the mask update, and is the inverse of the offset-to-byte selector.

Test Plan:
- Reset, then write 0x123 <- 0xAB, then flush -> mem_line_addr = 0x12, mem_mask = 16'h0008, mem_line[31:24] = 0xAB, all other bytes 0, mem_valid rises one cycle after flush.
- Sixteen writes 0x450..0x45F with data 0x00..0x0F, mem_ready = 1 -> a single emit with mask 16'hFFFF and mem_line = 128'h0F0E...0100. No flush needed. Busy drops 1 cycle after the handshake.
- Write 0x200 <- 0x11, then a write to 0x310 -> wr_ready = 0 for the 0x310 write. Line 0x20 is emitted with mask 16'h0001. 0x310 is accepted the cycle after the handshake, giving a new line 0x31 with mask 16'h0001.
- mem_ready held low 5 cycles in FLUSH with wr_valid asserted -> mem_* stable, wr_ready = 0 throughout, nothing lost.
- Write 0x7A5 <- 0x01, then 0x7A5 <- 0x02 together with flush -> emitted byte 5 = 0x02, mask 16'h0020.
- Assert rst_n low while in FLUSH -> mem_valid = 0 immediately, mask = 0; after release, state is EMPTY and wr_ready = 1.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared widths, state encoding and constants for the line write-merge buffer.
package cache_pkg;

    localparam int ADDR_W     = 12;
    localparam int BYTE_W     = 8;
    localparam int LINE_BYTES = 16;
    localparam int OFFSET_W   = 4;
    localparam int TAG_W      = ADDR_W - OFFSET_W;

    localparam logic [LINE_BYTES-1:0] FULL_MASK = 16'hFFFF;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        MERGING = 2'd1,
        FLUSH   = 2'd2
    } state_t;

endpackage

// File: rtl/offset_2_lane.sv
// Block offset to one-hot byte-lane enable; drives both lane writes and mask update.
module offset_2_lane
    import cache_pkg::*;
(
    input  logic [OFFSET_W-1:0]   i_offset,
    output logic [LINE_BYTES-1:0] o_lane
);

    generate
        for (genvar gi = 0; gi < LINE_BYTES; gi++) begin : g_lane
            assign o_lane[gi] = (i_offset == OFFSET_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/line_write_merge.sv
// Collects single-byte writes into one 16-byte line plus byte mask and hands the
// merged line to memory when full, on a line-address miss, or on flush.
module line_write_merge
    import cache_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [BYTE_W-1:0]            wr_byte,
    input  logic                         flush,
    output logic                         mem_valid,
    input  logic                         mem_ready,
    output logic [TAG_W-1:0]             mem_line_addr,
    output logic [LINE_BYTES*BYTE_W-1:0] mem_line,
    output logic [LINE_BYTES-1:0]        mem_mask,
    output logic                         busy
);

    state_t                         r_state;
    state_t                         w_state_next;
    logic [TAG_W-1:0]               r_line_addr;
    logic [LINE_BYTES*BYTE_W-1:0]   r_line;
    logic [LINE_BYTES-1:0]          r_mask;

    logic [LINE_BYTES-1:0]          w_lane;
    logic [LINE_BYTES*BYTE_W-1:0]   w_base_line;
    logic [LINE_BYTES-1:0]          w_base_mask;
    logic [LINE_BYTES*BYTE_W-1:0]   w_line_merged;
    logic [LINE_BYTES-1:0]          w_mask_merged;
    logic                           w_hit;
    logic                           w_accept;
    logic                           w_handshake;

    offset_2_lane u_offset_2_lane (
        .i_offset (wr_addr[OFFSET_W-1:0]),
        .o_lane   (w_lane)
    );

    assign w_hit       = (wr_addr[ADDR_W-1:OFFSET_W] == r_line_addr);
    assign wr_ready    = (r_state == EMPTY) || ((r_state == MERGING) && w_hit);
    assign w_accept    = wr_valid && wr_ready;
    assign mem_valid   = (r_state == FLUSH);
    assign w_handshake = mem_valid && mem_ready;
    assign busy        = (r_state != EMPTY);

    // A write into an empty buffer starts from a clean line, so unwritten bytes stay 0.
    assign w_base_line   = (r_state == EMPTY) ? '0 : r_line;
    assign w_base_mask   = (r_state == EMPTY) ? '0 : r_mask;
    assign w_mask_merged = w_base_mask | w_lane;

    generate
        for (genvar gi = 0; gi < LINE_BYTES; gi++) begin : g_merge
            assign w_line_merged[gi*BYTE_W +: BYTE_W] =
                w_lane[gi] ? wr_byte : w_base_line[gi*BYTE_W +: BYTE_W];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            EMPTY: begin
                if (w_accept) w_state_next = MERGING;
            end
            MERGING: begin
                // A miss is never accepted here, so wr_valid without accept means a miss.
                if (w_accept) begin
                    if ((w_mask_merged == FULL_MASK) || flush) w_state_next = FLUSH;
                end else if (wr_valid || flush) begin
                    w_state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (mem_ready) w_state_next = EMPTY;
            end
            default: w_state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_line_addr <= '0;
            r_line      <= '0;
            r_mask      <= '0;
        end else if (w_handshake) begin
            r_line <= '0;
            r_mask <= '0;
        end else if (w_accept) begin
            r_line_addr <= wr_addr[ADDR_W-1:OFFSET_W];
            r_line      <= w_line_merged;
            r_mask      <= w_mask_merged;
        end
    end

    assign mem_line_addr = r_line_addr;
    assign mem_line      = r_line;
    assign mem_mask      = r_mask;

endmodule

// File: tb/tb_line_write_merge.sv
// Directed bench: stimulus pushes expected emitted lines into a queue, a monitor pops on each handshake.
module tb_line_write_merge;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         wr_valid = 1'b0;
    logic         wr_ready;
    logic [11:0]  wr_addr = '0;
    logic [7:0]   wr_byte = '0;
    logic         flush = 1'b0;
    logic         mem_valid;
    logic         mem_ready = 1'b1;
    logic [7:0]   mem_line_addr;
    logic [127:0] mem_line;
    logic [15:0]  mem_mask;
    logic         busy;

    typedef struct {
        logic [7:0]   a;
        logic [15:0]  m;
        logic [127:0] l;
    } emit_t;

    emit_t        q[$];
    emit_t        e;
    int           checks = 0;
    int           failures = 0;
    int           w;
    logic [127:0] l2;

    line_write_merge dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_byte       (wr_byte),
        .flush         (flush),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_line_addr (mem_line_addr),
        .mem_line      (mem_line),
        .mem_mask      (mem_mask),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] a, input logic [15:0] m, input logic [127:0] l);
        emit_t x;
        x.a = a;
        x.m = m;
        x.l = l;
        q.push_back(x);
    endtask

    // Holds the write until accepted; waits = cycles spent stalled.
    task automatic wr(input logic [11:0] a, input logic [7:0] d, output int waits);
        waits    = 0;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_byte  = d;
        #1;
        while (!wr_ready && waits < 40) begin
            @(posedge clk);
            #2;
            waits++;
        end
        if (!wr_ready) begin
            checks++;
            failures++;
            $display("FAIL wr_timeout: addr %03h never accepted, wr_ready=%0b required 1", a, wr_ready);
        end
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        chk("drain_queue_empty", q.size(), 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && mem_valid && mem_ready) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL emit_unexpected: got addr=%02h mask=%04h line=%032h required no emit",
                             mem_line_addr, mem_mask, mem_line);
                end else begin
                    e = q.pop_front();
                    if (mem_line_addr !== e.a || mem_mask !== e.m || mem_line !== e.l) begin
                        failures++;
                        $display("FAIL emit: got addr=%02h mask=%04h line=%032h required addr=%02h mask=%04h line=%032h",
                                 mem_line_addr, mem_mask, mem_line, e.a, e.m, e.l);
                    end else begin
                        $display("emit addr=%02h mask=%04h line=%032h ok", mem_line_addr, mem_mask, mem_line);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values, sampled while reset is asserted.
        #3;
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mask", mem_mask, 0);
        chk("rst_line", mem_line, 0);
        chk("rst_line_addr", mem_line_addr, 0);
        #9;
        rst_n = 1'b1;
        tick();

        // Single byte then flush; mem_valid appears the cycle after flush.
        push(8'h12, 16'h0008, 128'hAB << 24);
        wr(12'h123, 8'hAB, w);
        chk("t1_busy_merging", busy, 1);
        flush = 1'b1;
        #1;
        chk("t1_valid_before", mem_valid, 0);
        tick();
        flush = 1'b0;
        chk("t1_valid_after", mem_valid, 1);
        chk("t1_wr_ready_flush", wr_ready, 0);
        drain();
        chk("t1_busy_idle", busy, 0);

        // Full line auto-emits without flush.
        l2 = '0;
        for (int i = 0; i < 16; i++) l2[8*i +: 8] = 8'(i);
        push(8'h45, 16'hFFFF, l2);
        for (int i = 0; i < 16; i++) wr(12'h450 + 12'(i), 8'(i), w);
        chk("t2_valid_full", mem_valid, 1);
        chk("t2_busy_flush", busy, 1);
        tick();
        chk("t2_busy_drop", busy, 0);
        drain();

        // Miss stalls, old line emits, miss accepted the cycle after the handshake.
        push(8'h20, 16'h0001, 128'h11);
        wr(12'h200, 8'h11, w);
        wr(12'h310, 8'h22, w);
        chk("t3_miss_waits", w, 2);
        chk("t3_new_addr", mem_line_addr, 8'h31);
        chk("t3_new_mask", mem_mask, 16'h0001);
        push(8'h31, 16'h0001, 128'h22);
        pulse_flush();
        drain();

        // Backpressure: outputs stable and writes stalled while mem_ready is low.
        push(8'h60, 16'h0020, 128'h5A << 40);
        wr(12'h605, 8'h5A, w);
        mem_ready = 1'b0;
        pulse_flush();
        wr_valid = 1'b1;
        wr_addr  = 12'h606;
        wr_byte  = 8'h77;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t4_valid_hold", mem_valid, 1);
            chk("t4_wr_ready_low", wr_ready, 0);
            chk("t4_addr_hold", mem_line_addr, 8'h60);
            chk("t4_mask_hold", mem_mask, 16'h0020);
            chk("t4_line_hold", mem_line, 128'h5A << 40);
            tick();
        end
        mem_ready = 1'b1;
        wr(12'h606, 8'h77, w);
        push(8'h60, 16'h0040, 128'h77 << 48);
        pulse_flush();
        drain();

        // Same-offset rewrite with flush in the same cycle: last write wins.
        push(8'h7A, 16'h0020, 128'h02 << 40);
        wr(12'h7A5, 8'h01, w);
        flush = 1'b1;
        wr(12'h7A5, 8'h02, w);
        flush = 1'b0;
        chk("t5_valid", mem_valid, 1);
        drain();

        // Asynchronous reset during FLUSH drops the line without handshake.
        wr(12'h100, 8'h33, w);
        mem_ready = 1'b0;
        pulse_flush();
        chk("t6_valid_before_rst", mem_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid_rst", mem_valid, 0);
        chk("t6_mask_rst", mem_mask, 0);
        chk("t6_line_rst", mem_line, 0);
        chk("t6_busy_rst", busy, 0);
        #3;
        rst_n = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("t6_wr_ready_after", wr_ready, 1);
        chk("t6_busy_after", busy, 0);
        tick();
        tick();
        tick();
        chk("final_queue_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
